seg_display_scan: RTL
=====================

# seg_display_scan

Time-multiplexed, brightness-controlled four-digit seven-segment driver. It sits directly downstream of the Clock time-keeping counters. It takes four hex/BCD nibbles plus per-digit decimal-point and blank masks, and drives the board's SegmentDrivers/SevenSegment pins. Inputs are captured once per frame so a digit never tears mid-scan. Brightness comes from Slide_Switch as a 4-level PWM within each digit slot.

## Interface
- REFRESH_DIV, 50000: clock cycles per digit slot (100 MHz → 2 kHz slot, 500 Hz frame). Must be a multiple of 4 and ≥ 8.
- Clk_100M  in  1  system clock; all state is clocked on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Digits  in  16  nibble i = Digits[4i+3:4i] is digit i; digit 0 is the rightmost.
- DP  in  4  bit i = 1 lights the decimal point of digit i.
- Blank  in  4  bit i = 1 forces digit i dark.
- Slide_Switch  in  2  brightness level L, 0..3; 2'b11 is full brightness.
- SegmentDrivers  out  4  active-low digit enables; bit i drives digit i.
- SevenSegment  out  8  active-low segments; [7]=DP, [6:0]=g..a.
- Frame_Tick  out  1  one-cycle pulse at the start of each captured frame.

## Operation
- Slot counter s runs 0..REFRESH_DIV-1. Digit index d runs 0→1→2→3→0 and advances when s wraps.
- Snapshot registers hold Digits, DP, Blank and L.
  - They load on the edge that moves (d,s) from (3,REFRESH_DIV-1) to (0,0).
  - Inputs are ignored at all other times.
- Enable rule, with Q = REFRESH_DIV/4: digit d is lit when s < Q*(L+1) and snapshot Blank[d] = 0. Duty cycle is 25/50/75/100 %.
- When lit:
  - SegmentDrivers = ~(1<<d).
  - SevenSegment = {~DP[d], seg(nibble d)}.
- When not lit: SegmentDrivers = 4'hF and SevenSegment = 8'hFF. Only one digit is ever enabled at a time.
- seg() gives the 8-bit value with DP off, active-low:
  - 0:C0, 1:F9, 2:A4, 3:B0, 4:99, 5:92, 6:82, 7:F8
  - 8:80, 9:90, A:88, b:83, C:C6, d:A1, E:86, F:8E
- Digit changes go dark between slots. This falls out of the enable rule for L<3. At L=3 no dead cycle is inserted.

## Timing
- All outputs are registered. Pins in cycle k reflect (d,s) and the snapshot of cycle k-1, so latency is 1 cycle.
- Reset behaviour (asynchronous):
  - s=0, d=0.
  - Snapshot: Digits=0, DP=0, Blank=4'hF, L=0.
  - Outputs: SegmentDrivers=4'hF, SevenSegment=8'hFF, Frame_Tick=0.
- The first frame after reset (4·REFRESH_DIV cycles) is fully dark. No Frame_Tick is issued for it.
- Frame_Tick is high for exactly one cycle: the first cycle in which the pins show digit 0, slot 0 from a newly loaded snapshot. The period is 4·REFRESH_DIV cycles.
- Input changes at any time other than the load edge take effect only after the next load. A change coincident with the load edge is captured.
- Slide_Switch changes likewise take effect only at the frame boundary.
- Reset asserted mid-frame forces the reset values immediately, independent of the clock. Counting restarts from (0,0) on the first edge after release.

## Test plan
All scenarios use REFRESH_DIV=8 (Q=2).
- **Reset.** Reset high, then low; Digits=16'h1234, L=3. Required: pins 4'hF/8'hFF for the first 32 cycles and no Frame_Tick. Then Frame_Tick=1 for 1 cycle.
- **Full-brightness scan.** Same inputs, L=3, Blank=0, DP=0. After Frame_Tick, each digit lights for 8 cycles in this order:
  - 1110/8'h99
  - 1101/8'hB0
  - 1011/8'hA4
  - 0111/8'hF9
- **Dimmest level.** L=0. Each digit lights for cycles s=0..1 only; pins are 4'hF/8'hFF for s=2..7.
- **No tearing.** Change Digits to 16'hABCD mid-frame. The current frame still shows 1234. After the next Frame_Tick, digit 0 shows 8'hA1 and digit 3 shows 8'h88.
- **Masks.** Blank=4'b1000, DP=4'b0001, L=3. Digit 0 shows 8'h19; digit 3 slot is all-dark (4'hF/8'hFF).
- **Hex sweep.** Cycle digit 0 through 0..F across frames. Each frame matches the seg() list above.

Source files
------------

// File: rtl/seg_display_scan_if.sv
// seg_display_scan_if: digit data, masks and brightness in; segment/digit pins and frame pulse out.
`default_nettype none

interface seg_display_scan_if;
  logic [15:0] Digits;
  logic [3:0]  DP;
  logic [3:0]  Blank;
  logic [1:0]  Slide_Switch;
  logic [3:0]  SegmentDrivers;
  logic [7:0]  SevenSegment;
  logic        Frame_Tick;

  modport master (
    output Digits, DP, Blank, Slide_Switch,
    input  SegmentDrivers, SevenSegment, Frame_Tick
  );

  modport slave (
    input  Digits, DP, Blank, Slide_Switch,
    output SegmentDrivers, SevenSegment, Frame_Tick
  );
endinterface

`default_nettype wire

// File: rtl/seg_display_scan.sv
// seg_display_scan: four-digit multiplexed seven-segment driver with per-frame input
// snapshot and four-level PWM brightness inside each digit slot.
`default_nettype none

module seg_display_scan #(
  parameter int REFRESH_DIV = 50000
) (
  input  wire logic         Clk_100M,
  input  wire logic         Reset,
  seg_display_scan_if.slave bus
);

  localparam int SW = $clog2(REFRESH_DIV);
  localparam int Q  = REFRESH_DIV / 4;

  logic [SW-1:0] slot;
  logic [1:0]    digit;
  logic [15:0]   snap_digits;
  logic [3:0]    snap_dp;
  logic [3:0]    snap_blank;
  logic [1:0]    snap_level;
  logic          load_pending;
  logic [3:0]    drivers;
  logic [7:0]    segments;
  logic          frame_tick;

  logic          slot_end;
  logic          load;
  logic [SW:0]   on_limit;
  logic [3:0]    nibble;
  logic          lit;

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] r;
    case (n)
      4'h0: r = 7'h40;  4'h1: r = 7'h79;  4'h2: r = 7'h24;  4'h3: r = 7'h30;
      4'h4: r = 7'h19;  4'h5: r = 7'h12;  4'h6: r = 7'h02;  4'h7: r = 7'h78;
      4'h8: r = 7'h00;  4'h9: r = 7'h10;  4'hA: r = 7'h08;  4'hB: r = 7'h03;
      4'hC: r = 7'h46;  4'hD: r = 7'h21;  4'hE: r = 7'h06;  default: r = 7'h0E;
    endcase
    return r;
  endfunction

  assign slot_end = (slot == SW'(REFRESH_DIV - 1));
  assign load     = slot_end && (digit == 2'd3);
  assign nibble   = snap_digits[{digit, 2'b00} +: 4];

  always_comb begin
    on_limit = (SW+1)'(Q);
    case (snap_level)
      2'd0:    on_limit = (SW+1)'(Q);
      2'd1:    on_limit = (SW+1)'(2 * Q);
      2'd2:    on_limit = (SW+1)'(3 * Q);
      default: on_limit = (SW+1)'(REFRESH_DIV);
    endcase
  end

  assign lit = ({1'b0, slot} < on_limit) && !snap_blank[digit];

  always_ff @(posedge Clk_100M or posedge Reset) begin
    if (Reset) begin
      slot         <= '0;
      digit        <= 2'd0;
      snap_digits  <= 16'h0000;
      snap_dp      <= 4'h0;
      snap_blank   <= 4'hF;
      snap_level   <= 2'd0;
      load_pending <= 1'b0;
      drivers      <= 4'hF;
      segments     <= 8'hFF;
      frame_tick   <= 1'b0;
    end else begin
      slot <= slot_end ? '0 : slot + SW'(1);
      if (slot_end) digit <= digit + 2'd1;
      // Inputs are sampled only on the frame-wrap edge so a frame never mixes old and new data.
      if (load) begin
        snap_digits <= bus.Digits;
        snap_dp     <= bus.DP;
        snap_blank  <= bus.Blank;
        snap_level  <= bus.Slide_Switch;
      end
      load_pending <= load;
      frame_tick   <= load_pending;
      if (lit) begin
        drivers  <= ~(4'b0001 << digit);
        segments <= {~snap_dp[digit], seg_of(nibble)};
      end else begin
        drivers  <= 4'hF;
        segments <= 8'hFF;
      end
    end
  end

  assign bus.SegmentDrivers = drivers;
  assign bus.SevenSegment   = segments;
  assign bus.Frame_Tick     = frame_tick;

endmodule

`default_nettype wire
